// File: rtl/aq_ifu_icache_data_bank_ctrl.sv
// ---------------------------------------------------------------------------
// aq_ifu_icache_data_bank_ctrl
//
// I-cache data-array controller for WAYS x BANKS single-port 32-bit SRAM
// macros. Fetch reads access one row of every bank in the selected ways and
// return data with a fixed, fully pipelined latency: 1 cycle if RD_OUT_REG=0,
// 2 cycles if RD_OUT_REG=1. Refill beats from the BIU are held in a 2-entry
// write buffer and written into SRAM cycles that reads leave idle. A
// starvation counter forces a write once reads have blocked the buffer for
// STARVE_MAX cycles in a row.
//
// Ports
//   forever_cpuclk / cpurst_b   clock, asynchronous active-low reset
//   rd_req_*                    fetch read request (valid/ready, index, way mask)
//   rd_rsp_*                    read response (valid, {way..}{bank..} data)
//   refill_*                    refill beat input (valid/ready, line, way,
//                               data, last), done pulse, sticky error
//   sram_*                      macro controls: per-macro chip enables, shared
//                               write enable/address/write data, and read data
// ---------------------------------------------------------------------------
module aq_ifu_icache_data_bank_ctrl #(
   parameter int WAYS       = 2,
   parameter int BANKS      = 4,
   parameter int IDX_W      = 11,
   parameter int LINE_BEATS = 4,
   parameter int STARVE_MAX = 4,
   parameter int RD_OUT_REG = 1,
   localparam int CW        = $clog2(LINE_BEATS),
   localparam int WW        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                        forever_cpuclk,
   input  logic                        cpurst_b,
   input  logic                        rd_req_vld,
   output logic                        rd_req_rdy,
   input  logic [IDX_W-1:0]            rd_req_idx,
   input  logic [WAYS-1:0]             rd_req_way_mask,
   output logic                        rd_rsp_vld,
   output logic [WAYS*BANKS*32-1:0]    rd_rsp_data,
   input  logic                        refill_vld,
   output logic                        refill_rdy,
   input  logic [IDX_W-CW-1:0]         refill_line_idx,
   input  logic [WW-1:0]               refill_way,
   input  logic [BANKS*32-1:0]         refill_data,
   input  logic                        refill_last,
   output logic                        refill_done,
   output logic                        refill_err,
   output logic [WAYS*BANKS-1:0]       sram_cen_b,
   output logic                        sram_gwen_b,
   output logic [IDX_W-1:0]            sram_idx,
   output logic [BANKS*32-1:0]         sram_din,
   input  logic [WAYS*BANKS*32-1:0]    sram_dout
);

   localparam int ROW_W = BANKS * 32;
   localparam int RSP_W = WAYS * ROW_W;
   localparam int SW    = $clog2(STARVE_MAX + 1);

   // Write buffer storage: two entries addressed by 1-bit pointers.
   logic [IDX_W-1:0] buf_idx_q  [2];
   logic [WW-1:0]    buf_way_q  [2];
   logic [ROW_W-1:0] buf_data_q [2];
   logic             buf_last_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic [1:0]       cnt_d;

   logic             init_done_q;
   logic [CW-1:0]    beat_q;
   logic [CW-1:0]    beat_d;
   logic             err_q;
   logic             err_d;
   logic [SW-1:0]    starve_q;
   logic [SW-1:0]    starve_d;
   logic             done_q;

   logic             rd_vld_p1_q;
   logic [WAYS-1:0]  rd_mask_p1_q;

   logic             buf_nempty_s;
   logic             buf_full_s;
   logic             starve_hit_s;
   logic             force_wr_s;
   logic             do_wr_s;
   logic             do_rd_s;
   logic             push_s;
   logic             beat_end_s;
   logic [IDX_W-1:0] head_idx_s;
   logic [WW-1:0]    head_way_s;
   logic [ROW_W-1:0] head_data_s;
   logic             head_last_s;
   logic [RSP_W-1:0] rd_q_masked_s;

   assign head_idx_s  = buf_idx_q[rd_ptr_q];
   assign head_way_s  = buf_way_q[rd_ptr_q];
   assign head_data_s = buf_data_q[rd_ptr_q];
   assign head_last_s = buf_last_q[rd_ptr_q];

   assign rd_req_rdy  = init_done_q && !force_wr_s;
   assign refill_rdy  = init_done_q && !buf_full_s;
   assign push_s      = refill_vld && refill_rdy;
   assign beat_end_s  = (beat_q == CW'(LINE_BEATS - 1));
   assign refill_done = done_q;
   assign refill_err  = err_q;

   // Arbitration between forced write, read, opportunistic write and idle.
   always_comb begin
      buf_nempty_s = (cnt_q != 2'd0);
      buf_full_s   = (cnt_q == 2'd2);
      starve_hit_s = (starve_q == SW'(STARVE_MAX));
      force_wr_s   = buf_nempty_s && (buf_full_s || starve_hit_s);
      do_wr_s      = 1'b0;
      do_rd_s      = 1'b0;
      if (!init_done_q) begin
         do_wr_s = 1'b0;
         do_rd_s = 1'b0;
      end else if (force_wr_s) begin
         do_wr_s = 1'b1;
      end else if (rd_req_vld) begin
         do_rd_s = 1'b1;
      end else if (buf_nempty_s) begin
         do_wr_s = 1'b1;
      end else begin
         do_wr_s = 1'b0;
      end
   end

   // SRAM macro controls for the winning access; idle keeps every macro off.
   always_comb begin
      sram_cen_b  = {(WAYS*BANKS){1'b1}};
      sram_gwen_b = 1'b1;
      sram_idx    = {IDX_W{1'b0}};
      sram_din    = {ROW_W{1'b0}};
      if (do_wr_s) begin
         for (int w = 0; w < WAYS; w++) begin
            if (head_way_s == WW'(w)) begin
               sram_cen_b[w*BANKS +: BANKS] = {BANKS{1'b0}};
            end else begin
               sram_cen_b[w*BANKS +: BANKS] = {BANKS{1'b1}};
            end
         end
         sram_gwen_b = 1'b0;
         sram_idx    = head_idx_s;
         sram_din    = head_data_s;
      end else if (do_rd_s) begin
         for (int w = 0; w < WAYS; w++) begin
            if (rd_req_way_mask[w]) begin
               sram_cen_b[w*BANKS +: BANKS] = {BANKS{1'b0}};
            end else begin
               sram_cen_b[w*BANKS +: BANKS] = {BANKS{1'b1}};
            end
         end
         sram_idx = rd_req_idx;
      end else begin
         sram_gwen_b = 1'b1;
      end
   end

   // Buffer occupancy, beat counter, refill error and starvation next state.
   always_comb begin
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      err_d    = err_q;
      starve_d = starve_q;
      case ({push_s, do_wr_s})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      if (push_s) begin
         // A last beat must land on the final counter value and vice versa;
         // the counter clears on last or wraps naturally either way.
         if (refill_last != beat_end_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
         if (refill_last) begin
            beat_d = {CW{1'b0}};
         end else begin
            beat_d = beat_q + CW'(1);
         end
      end else begin
         beat_d = beat_q;
      end
      if (do_wr_s || !buf_nempty_s) begin
         starve_d = {SW{1'b0}};
      end else if (do_rd_s && !starve_hit_s) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Write buffer storage and pointers.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int i = 0; i < 2; i++) begin
            buf_idx_q[i]  <= {IDX_W{1'b0}};
            buf_way_q[i]  <= {WW{1'b0}};
            buf_data_q[i] <= {ROW_W{1'b0}};
            buf_last_q[i] <= 1'b0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_s) begin
            buf_idx_q[wr_ptr_q]  <= {refill_line_idx, beat_q};
            buf_way_q[wr_ptr_q]  <= refill_way;
            buf_data_q[wr_ptr_q] <= refill_data;
            buf_last_q[wr_ptr_q] <= refill_last;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (do_wr_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

   // Control state: init flag, beat counter, sticky error, starvation, done pulse.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         init_done_q <= 1'b0;
         beat_q      <= {CW{1'b0}};
         err_q       <= 1'b0;
         starve_q    <= {SW{1'b0}};
         done_q      <= 1'b0;
      end else begin
         init_done_q <= 1'b1;
         beat_q      <= beat_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
         done_q      <= do_wr_s && head_last_s;
      end
   end

   // Read pipeline stage aligned with the cycle SRAM Q is valid.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_vld_p1_q  <= 1'b0;
         rd_mask_p1_q <= {WAYS{1'b0}};
      end else begin
         rd_vld_p1_q  <= do_rd_s;
         rd_mask_p1_q <= do_rd_s ? rd_req_way_mask : {WAYS{1'b0}};
      end
   end

   // Zero the slices of ways that were not enabled for this read.
   always_comb begin
      rd_q_masked_s = {RSP_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         if (rd_mask_p1_q[w]) begin
            rd_q_masked_s[w*ROW_W +: ROW_W] = sram_dout[w*ROW_W +: ROW_W];
         end else begin
            rd_q_masked_s[w*ROW_W +: ROW_W] = {ROW_W{1'b0}};
         end
      end
   end

   generate
      if (RD_OUT_REG != 0) begin : g_out_reg
         logic             rsp_vld_q;
         logic [RSP_W-1:0] rsp_data_q;

         // Output register; data holds its last value between responses.
         always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
               rsp_vld_q  <= 1'b0;
               rsp_data_q <= {RSP_W{1'b0}};
            end else begin
               rsp_vld_q <= rd_vld_p1_q;
               if (rd_vld_p1_q) begin
                  rsp_data_q <= rd_q_masked_s;
               end
            end
         end

         assign rd_rsp_vld  = rsp_vld_q;
         assign rd_rsp_data = rsp_data_q;
      end else begin : g_out_flow
         assign rd_rsp_vld  = rd_vld_p1_q;
         assign rd_rsp_data = rd_q_masked_s;
      end
   endgenerate

endmodule
